// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state (S_IDLE, S_WAIT, S_DRAIN)
//   fetch_entry_t : one instruction buffer entry {pc, instr}
//   align_word()  : clears the byte-offset bits of an address
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    // S_IDLE : no request outstanding
    // S_WAIT : request outstanding, its result goes into the buffer
    // S_DRAIN: request outstanding, its result is thrown away (redirected)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus plus the decode-side handshake.
//   Memory side : o_imem_req_w / o_imem_addr_w (fetch -> mem),
//                 i_imem_ack_w / i_imem_rdata_w (mem -> fetch)
//   Decode side : o_instr_valid_w / o_instr_w / o_instr_pc_w (fetch -> decode),
//                 i_instr_ready_w (decode -> fetch)
// Handshakes: the memory request is a level held (address stable) until the
// cycle i_imem_ack_w is high, which may be the very first cycle of the
// request; at most one request is ever outstanding. Toward decode, an entry
// transfers in a cycle where valid and ready are both high; while valid is
// high and ready low the head entry does not change.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic               o_imem_req_w;
    logic [ADDR_W-1:0]  o_imem_addr_w;
    logic               i_imem_ack_w;
    logic [INSTR_W-1:0] i_imem_rdata_w;
    logic               o_instr_valid_w;
    logic [INSTR_W-1:0] o_instr_w;
    logic [ADDR_W-1:0]  o_instr_pc_w;
    logic               i_instr_ready_w;

    // master: the fetch unit
    modport master (
        output o_imem_req_w, o_imem_addr_w,
        input  i_imem_ack_w, i_imem_rdata_w,
        output o_instr_valid_w, o_instr_w, o_instr_pc_w,
        input  i_instr_ready_w
    );

    // slave: memory plus decode stage
    modport slave (
        input  o_imem_req_w, o_imem_addr_w,
        output i_imem_ack_w, i_imem_rdata_w,
        input  o_instr_valid_w, o_instr_w, o_instr_pc_w,
        output i_instr_ready_w
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer of {pc, instr} entries.
//   i_clk_w, i_rst_w : clock, synchronous active-high reset (clears contents)
//   i_flush_w        : empties the buffer; wins over push and pop
//   i_push_w/_data_w : write an entry (dropped if full and not popping)
//   i_pop_w          : remove head (ignored when empty)
//   o_valid_w/o_head_w : head entry, held stable until popped
//   o_count_w        : number of stored entries
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk_w,
    input  logic             i_rst_w,
    input  logic             i_flush_w,
    input  logic             i_push_w,
    input  fetch_entry_t     i_push_data_w,
    input  logic             i_pop_w,
    output logic             o_valid_w,
    output fetch_entry_t     o_head_w,
    output logic [CNT_W-1:0] o_count_w
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = i_pop_w && (count != '0);
    assign push_ok = i_push_w && ((count < FULL) || pop_ok);

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Contents cleared so the head reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush_w) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= i_push_data_w;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_valid_w = (count != '0);
    assign o_head_w  = mem[rd_ptr];
    assign o_count_w = count;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a small decode-facing buffer.
//   i_clk_w, i_rst_w      : clock, synchronous active-high reset
//   i_pc_w / o_pc_next_w  : PC register value in, next PC out (loaded every cycle)
//   i_branch_w, i_branch_target_w : redirect from execute (flushes the buffer)
//   bus (master)          : instruction memory request/ack and decode handshake
//   o_state_w             : current FSM state, for debug
// Fetches one word per cycle while the buffer has room; a redirect with a
// request in flight marks that request's data for discard.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk_w,
    input  logic              i_rst_w,
    input  logic [ADDR_W-1:0] i_pc_w,
    output logic [ADDR_W-1:0] o_pc_next_w,
    input  logic              i_branch_w,
    input  logic [ADDR_W-1:0] i_branch_target_w,
    instr_fetch_if.master     bus,
    output fetch_state_t      o_state_w
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_t      state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic              fifo_valid;
    fetch_entry_t      fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop_eff;
    logic [CNT_W-1:0]  count_after_pop;
    logic              room_idle;
    logic              room_after_push;
    logic              push;

    // Room is judged after this cycle's pop so a full buffer being drained
    // by decode can still issue (or keep issuing) without a bubble.
    assign pop_eff         = fifo_valid && bus.i_instr_ready_w;
    assign count_after_pop = fifo_count - CNT_W'(pop_eff);
    assign room_idle       = count_after_pop < DEPTH_C;
    assign room_after_push = (count_after_pop + 1'b1) < DEPTH_C;

    assign push = (state == S_WAIT) && bus.i_imem_ack_w && !i_branch_w;

    always_comb begin
        o_pc_next_w = i_pc_w;
        if (i_rst_w) begin
            o_pc_next_w = '0;
        end else if (i_branch_w) begin
            o_pc_next_w = align_word(i_branch_target_w);
        end else if (push) begin
            o_pc_next_w = i_pc_w + PC_INC;
        end
    end

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!i_branch_w && room_idle) begin
                        state  <= S_WAIT;
                        req_q  <= 1'b1;
                        addr_q <= i_pc_w;
                    end
                end
                S_WAIT: begin
                    if (bus.i_imem_ack_w) begin
                        if (i_branch_w || !room_after_push) begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end else begin
                            // Back-to-back: the next word is the PC being loaded now.
                            addr_q <= i_pc_w + PC_INC;
                        end
                    end else if (i_branch_w) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The ack closes the stale request even if another redirect
                    // arrives with it; there is nothing left to wait for.
                    if (bus.i_imem_ack_w) begin
                        state <= S_IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk_w       (i_clk_w),
        .i_rst_w       (i_rst_w),
        .i_flush_w     (i_branch_w),
        .i_push_w      (push),
        .i_push_data_w ('{pc: addr_q, instr: bus.i_imem_rdata_w}),
        .i_pop_w       (bus.i_instr_ready_w),
        .o_valid_w     (fifo_valid),
        .o_head_w      (fifo_head),
        .o_count_w     (fifo_count)
    );

    assign bus.o_imem_req_w    = req_q;
    assign bus.o_imem_addr_w   = addr_q;
    assign bus.o_instr_valid_w = fifo_valid;
    assign bus.o_instr_w       = fifo_head.instr;
    assign bus.o_instr_pc_w    = fifo_head.pc;
    assign o_state_w           = state;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-002 i_clk_w  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_w  input  1  reset; synchronous, active-high.
REQ-004 i_pc_w  input  32  current PC from the PC register.
REQ-005 o_pc_next_w  output  32  next PC to the PC register, which loads every cycle.
REQ-006 i_branch_w  input  1  redirect request from execute.
REQ-007 i_branch_target_w  input  32  redirect address.
REQ-008 o_imem_req_w  output  1  instruction memory request, registered.
REQ-009 o_imem_addr_w  output  32  request address, registered.
REQ-010 i_imem_ack_w  input  1  read completed; i_imem_rdata_w valid this cycle.
REQ-011 i_imem_rdata_w  input  32  instruction word.
REQ-012 o_instr_valid_w  output  1  buffer head valid toward decode.
REQ-013 o_instr_w  output  32  buffer head instruction.
REQ-014 o_instr_pc_w  output  32  address the head instruction was fetched from.
REQ-015 i_instr_ready_w  input  1  decode accepts head; pop when valid and ready.

Function
REQ-016 FSM states: S_IDLE (no request outstanding), S_WAIT (request outstanding, result kept), S_DRAIN (request outstanding, result discarded).
REQ-017 S_IDLE with buffer room (count < FIFO_DEPTH, pop counted) and no branch: latch o_imem_addr_w = i_pc_w, assert o_imem_req_w, go S_WAIT.
REQ-018 o_imem_req_w is high exactly in S_WAIT and S_DRAIN; o_imem_addr_w is stable while req is high.
REQ-019 Ack is legal in the first cycle req is high; at most one request is outstanding.
REQ-020 S_WAIT, ack, no branch: push {o_imem_addr_w, i_imem_rdata_w}; o_pc_next_w = i_pc_w + 4 (mod 2^32, wrap 0xFFFFFFFC -> 0x00000000).
REQ-021 After the REQ-020 push, if room remains: stay S_WAIT with o_imem_addr_w = i_pc_w + 4 (back-to-back, one fetch per cycle); otherwise go S_IDLE.
REQ-022 o_pc_next_w = i_pc_w in every cycle with neither an accepted ack nor a branch.
REQ-023 Branch in any state: o_pc_next_w = {i_branch_target_w[31:2], 2'b00}; buffer flushed that cycle; branch overrides pop and push.
REQ-024 Branch in S_WAIT without ack -> S_DRAIN; with ack same cycle -> data discarded, go S_IDLE.
REQ-025 Branch in S_IDLE -> stay S_IDLE; branch in S_DRAIN -> stay S_DRAIN.
REQ-026 S_DRAIN, ack: data discarded, go S_IDLE; o_pc_next_w unchanged by the ack.
REQ-027 Pushed instruction visible on o_instr_valid_w the cycle after ack (1-cycle latency); head holds stable while valid and not ready.
REQ-028 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-029 Buffer never overflows; no push occurs when full; pop on empty is ignored.

Reset
REQ-030 Reset in any state, including mid-request: state S_IDLE, buffer empty, o_imem_req_w = 0, o_imem_addr_w = 0, o_instr_valid_w = 0, o_instr_w = 0, o_instr_pc_w = 0.
REQ-031 During reset o_pc_next_w = 0; an ack arriving in a reset cycle is discarded.
REQ-032 First request: o_imem_req_w high in the second cycle after reset deasserts, address = i_pc_w (0).

Structure
REQ-033 Package fetch_pkg holds the FSM state enum, INSTR_W = 32, ADDR_W = 32, PC_INC = 4.
REQ-034 Buffer is sub-module fetch_fifo (synchronous FIFO of {pc, instr}, flush input, count output); FSM and next-PC select remain in instr_fetch.

Verification
REQ-035 Reset release, ack every cycle, ready held high: addresses 0x0, 0x4, 0x8 on consecutive cycles; o_instr_pc_w follows one cycle behind; PC sequence 0, 4, 8, 12.
REQ-036 Ready held low, FIFO_DEPTH = 2: exactly two fetches (0x0, 0x4), then req drops; o_pc_next_w holds 0x8; ready high -> fetch 0x8 resumes.
REQ-037 Branch to 0x103 while request to 0x8 is outstanding and ack arrives 3 cycles later: o_pc_next_w = 0x100; the 0x8 data never reaches decode; next request address = 0x100.
REQ-038 Branch to 0x200 in the same cycle as ack for 0x10 with two entries buffered: buffer empty next cycle; 0x10 discarded; next fetch 0x200.
REQ-039 i_pc_w = 0xFFFFFFFC, ack: o_pc_next_w = 0x00000000; instruction tagged 0xFFFFFFFC.
REQ-040 Reset asserted for one cycle mid-request with ack in that cycle: all outputs zero next cycle; no instruction delivered; fetch restarts at 0x0.
